// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer sharing one memory between the core port (C) and a loader/DMA port (D).
// Each access is IDLE -> ISSUE (one-cycle strobe) -> WAIT (LAT cycles) -> RESP (one-cycle ready).
module mem_port_arbiter #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ready,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  // Counter only has to hold LAT-1.
  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;      // 0 = C, 1 = D
  logic          win_q, win_d;        // port owning the access in flight
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          m_en_q, m_en_d;
  logic          m_we_q, m_we_d;
  logic          c_ready_q, c_ready_d;
  logic          d_ready_q, d_ready_d;
  logic          busy_q, busy_d;
  logic          grant;

  // Next-state, arbitration, request latching and registered-output decode.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    m_en_d    = 1'b0;
    m_we_d    = 1'b0;
    c_ready_d = 1'b0;
    d_ready_d = 1'b0;
    busy_d    = 1'b0;
    // Tie goes to the port that was not served last; otherwise the sole requester.
    grant     = (c_req && d_req) ? ~last_q : d_req;

    case (state_q)
      S_IDLE: begin
        if (c_req || d_req) begin
          win_d   = grant;
          last_d  = grant;
          we_d    = grant ? d_we    : c_we;
          addr_d  = grant ? d_addr  : c_addr;
          wdata_d = grant ? d_wdata : c_wdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (!we_q) rdata_d = m_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    m_en_d    = (state_d == S_ISSUE);
    m_we_d    = (state_d == S_ISSUE) && we_d;
    c_ready_d = (state_d == S_RESP) && !win_d;
    d_ready_d = (state_d == S_RESP) && win_d;
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      c_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      c_ready_q <= c_ready_d;
      d_ready_q <= d_ready_d;
      busy_q    <= busy_d;
    end
  end

  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign c_ready = c_ready_q;
  assign d_ready = d_ready_q;
  assign c_rdata = rdata_q;
  assign d_rdata = rdata_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: three instances built with LAT = 2, 1 and 4.
module tb_mem_port_arbiter;

  typedef struct {
    int          inst;
    int          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        mem_clr;
  logic [2:0]  c_req, c_we, d_req, d_we;
  logic [31:0] c_addr [3];
  logic [31:0] c_wdata [3];
  logic [31:0] d_addr [3];
  logic [31:0] d_wdata [3];
  wire  [2:0]  c_ready, d_ready, m_en, m_we, busy;
  wire  [31:0] c_rdata [3];
  wire  [31:0] d_rdata [3];
  wire  [31:0] m_addr [3];
  wire  [31:0] m_wdata [3];
  wire  [31:0] m_rdata [3];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  exp_t        sb[$];
  logic [31:0] ref_mem [3][256];
  logic [31:0] last_rd [3];

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 4;
  endfunction

  function automatic logic [31:0] init_val(input int i, input logic [7:0] idx);
    if (idx == 8'd16) return 32'hDEAD_BEEF;
    return {8'hC0, 8'(i), 8'h5A, idx};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // DUTs plus a memory model whose read data is valid only LAT cycles after the strobe.
  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    logic [255:0] wr_v;
    logic [31:0]  wr_d [256];
    logic [L-1:0] pv;
    logic [31:0]  pd [L];

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(L)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .c_req   (c_req[g]),
      .c_we    (c_we[g]),
      .c_addr  (c_addr[g]),
      .c_wdata (c_wdata[g]),
      .c_ready (c_ready[g]),
      .c_rdata (c_rdata[g]),
      .d_req   (d_req[g]),
      .d_we    (d_we[g]),
      .d_addr  (d_addr[g]),
      .d_wdata (d_wdata[g]),
      .d_ready (d_ready[g]),
      .d_rdata (d_rdata[g]),
      .m_en    (m_en[g]),
      .m_we    (m_we[g]),
      .m_addr  (m_addr[g]),
      .m_wdata (m_wdata[g]),
      .m_rdata (m_rdata[g]),
      .busy    (busy[g])
    );

    always @(posedge clk) begin
      if (mem_clr) begin
        wr_v <= '0;
        pv   <= '0;
      end else begin
        if (m_en[g] && m_we[g]) begin
          wr_v[m_addr[g][9:2]] <= 1'b1;
          wr_d[m_addr[g][9:2]] <= m_wdata[g];
        end
        pv[0] <= m_en[g] & ~m_we[g];
        for (int k = 1; k < int'(L); k++) pv[k] <= pv[k-1];
      end
      pd[0] <= wr_v[m_addr[g][9:2]] ? wr_d[m_addr[g][9:2]] : init_val(g, m_addr[g][9:2]);
      for (int k = 1; k < int'(L); k++) pd[k] <= pd[k-1];
    end

    assign m_rdata[g] = pv[L-1] ? pd[L-1] : 32'hBAD0_BAD0;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Output monitor: pops the scoreboard on every ready and checks protocol invariants.
  initial begin
    int   men_cnt [3];
    logic men_prev [3];
    exp_t e;
    int   port;
    for (int i = 0; i < 3; i++) begin
      men_cnt[i]  = 0;
      men_prev[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (reset) begin
          men_cnt[i]  = 0;
          men_prev[i] = 1'b0;
        end else begin
          if (m_en[i]) begin
            if (men_prev[i]) check("m_en_consecutive", 1, 0);
            men_cnt[i]++;
          end
          men_prev[i] = m_en[i];
          if (c_ready[i] && d_ready[i]) check("ready_overlap", 1, 0);
          if ((c_ready[i] || d_ready[i]) && m_en[i]) check("ready_with_m_en", 1, 0);
          if (c_ready[i] || d_ready[i]) begin
            port = d_ready[i] ? 1 : 0;
            if (sb.size() == 0) begin
              check("unexpected_ready", 1, 0);
            end else begin
              e = sb.pop_front();
              check("sb_inst", 64'(i), 64'(e.inst));
              check("sb_port", 64'(port), 64'(e.port));
              check("ready_cycle", 64'(cyc), 64'(e.cyc));
              check("rdata", port ? d_rdata[i] : c_rdata[i], e.data);
              check("m_en_per_access", 64'(men_cnt[i]), 1);
            end
            men_cnt[i] = 0;
          end
        end
      end
    end
  end

  task automatic push_exp(input int inst, input int port, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata, input int ecyc);
    exp_t e;
    e.inst = inst;
    e.port = port;
    e.cyc  = ecyc;
    if (we) begin
      e.data = last_rd[inst];
      ref_mem[inst][addr[9:2]] = wdata;
    end else begin
      e.data = ref_mem[inst][addr[9:2]];
      last_rd[inst] = e.data;
    end
    sb.push_back(e);
  endtask

  task automatic wait_ready(input int inst, input int port);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (port == 1 ? d_ready[inst] : c_ready[inst]) seen = 1'b1;
    end
    if (!seen) check("ready_timeout", 0, 1);
  endtask

  // Single uncontended access: drive, check the strobe cycle, wait for ready, release.
  task automatic do_access(input int inst, input int port, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk);
    #1;
    if (port == 0) begin
      c_we[inst] = we; c_addr[inst] = addr; c_wdata[inst] = wdata; c_req[inst] = 1'b1;
    end else begin
      d_we[inst] = we; d_addr[inst] = addr; d_wdata[inst] = wdata; d_req[inst] = 1'b1;
    end
    push_exp(inst, port, we, addr, wdata, cyc + lat_of(inst) + 2);
    @(negedge clk);
    @(negedge clk);
    check("strobe_m_en", m_en[inst], 1);
    check("strobe_m_addr", m_addr[inst], addr);
    check("strobe_m_we", m_we[inst], we);
    if (we) check("strobe_m_wdata", m_wdata[inst], wdata);
    wait_ready(inst, port);
    @(posedge clk);
    #1;
    if (port == 0) c_req[inst] = 1'b0;
    else d_req[inst] = 1'b0;
  endtask

  initial begin
    int t0;
    reset   = 1'b1;
    mem_clr = 1'b1;
    c_req = '0; c_we = '0; d_req = '0; d_we = '0;
    for (int i = 0; i < 3; i++) begin
      c_addr[i] = '0; c_wdata[i] = '0; d_addr[i] = '0; d_wdata[i] = '0;
      last_rd[i] = '0;
      for (int j = 0; j < 256; j++) ref_mem[i][j] = init_val(i, 8'(j));
    end

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_c_ready", c_ready[i], 0);
      check("rst_d_ready", d_ready[i], 0);
      check("rst_m_en", m_en[i], 0);
      check("rst_m_we", m_we[i], 0);
      check("rst_busy", busy[i], 0);
      check("rst_m_addr", m_addr[i], 0);
      check("rst_m_wdata", m_wdata[i], 0);
      check("rst_rdata", c_rdata[i], 0);
    end
    @(posedge clk);
    #1;
    reset   = 1'b0;
    mem_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_m_en", m_en[0], 0);
      check("idle_busy", busy[0], 0);
    end

    // Core read, D write, core read-back (LAT=2).
    do_access(0, 0, 1'b0, 32'h40, 32'h0);
    do_access(0, 1, 1'b1, 32'h80, 32'h1234_5678);
    do_access(0, 0, 1'b0, 32'h80, 32'h0);

    // Reset during WAIT of a core read: no ready, state and rdata cleared.
    @(posedge clk);
    #1;
    c_we[0] = 1'b0; c_addr[0] = 32'h40; c_req[0] = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    c_req[0] = 1'b0;
    @(negedge clk);
    check("abort_busy_in_wait", busy[0], 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    @(negedge clk);
    check("abort_busy", busy[0], 0);
    check("abort_m_en", m_en[0], 0);
    check("abort_rdata", c_rdata[0], 0);
    check("abort_m_addr", m_addr[0], 0);
    repeat (6) @(negedge clk);

    // Both ports held out of reset: C, D, C, D with ready pulses 5 cycles apart.
    @(posedge clk);
    #1;
    t0 = cyc;
    c_we[0] = 1'b0; c_addr[0] = 32'h40;  c_req[0] = 1'b1;
    d_we[0] = 1'b0; d_addr[0] = 32'h100; d_req[0] = 1'b1;
    push_exp(0, 0, 1'b0, 32'h40,  32'h0, t0 + 4);
    push_exp(0, 1, 1'b0, 32'h100, 32'h0, t0 + 9);
    push_exp(0, 0, 1'b0, 32'h80,  32'h0, t0 + 14);
    push_exp(0, 1, 1'b0, 32'h44,  32'h0, t0 + 19);
    fork
      begin
        wait_ready(0, 0);
        @(posedge clk);
        #1;
        c_addr[0] = 32'h80;
        wait_ready(0, 0);
        @(posedge clk);
        #1;
        c_req[0] = 1'b0;
      end
      begin
        wait_ready(0, 1);
        @(posedge clk);
        #1;
        d_addr[0] = 32'h44;
        wait_ready(0, 1);
        @(posedge clk);
        #1;
        d_req[0] = 1'b0;
      end
    join

    // Mixed random accesses on the LAT=2 instance.
    for (int n = 0; n < 8; n++) begin
      do_access(0, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
    end

    // LAT=1 and LAT=4 instances.
    for (int i = 1; i < 3; i++) begin
      do_access(i, 0, 1'b0, 32'h40,  32'h0);
      do_access(i, 1, 1'b1, 32'h200, 32'hCAFE_F00D + 32'(i));
      do_access(i, 0, 1'b0, 32'h200, 32'h0);
      do_access(i, 1, 1'b0, 32'h3FC, 32'h0);
    end

    repeat (4) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares the single unified memory of the multicycle core between two requesters: the core's memory interface (port C) and a loader/DMA port (port D). It accepts one request at a time, issues a single-cycle memory strobe, waits a fixed memory latency and returns a one-cycle ready with registered read data. It sits between the multicycle datapath/controller and the memory, replacing the direct connection. The core's controller stalls its FSM until `c_ready` is seen.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `LAT`, default 2: memory read latency in cycles, must be ≥1. `m_rdata` is valid `LAT` cycles after the strobe cycle.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `c_req`, `c_we`, in, 1 each: core request and write enable.
- `c_addr`, in, AW: core address.
- `c_wdata`, in, DW: core write data.
- `c_ready`, out, 1: core access complete (one-cycle pulse).
- `c_rdata`, out, DW: read data, valid with `c_ready`.
- `d_req`, `d_we`, `d_addr`, `d_wdata`, `d_ready`, `d_rdata`: same as the port C signals, for port D.
- `m_en`, out, 1: memory strobe.
- `m_we`, out, 1: memory write enable.
- `m_addr`, out, AW: memory address.
- `m_wdata`, out, DW: memory write data.
- `m_rdata`, in, DW: memory read data.
- `busy`, out, 1: high in any state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - Otherwise select a winner and latch its `we`, `addr` and `wdata` into internal registers. Go to ISSUE.
- **Arbitration** is round-robin, using a `last` register (0 = C, 1 = D).
  - Only one request: that port wins.
  - Both requesting: the port not equal to `last` wins.
  - `last` updates to the winner on each grant. Reset sets `last` = D, so C wins the first tie.
- **ISSUE**
  - `m_en` = 1 for exactly this cycle. `m_we`, `m_addr` and `m_wdata` come from the latched registers.
  - Counter loads `LAT`-1. Go to WAIT.
- **WAIT**
  - `m_en` = 0, `m_we` = 0. `m_addr` and `m_wdata` hold their values.
  - While counter ≠ 0: decrement and stay in WAIT.
  - When counter = 0: `m_rdata` is valid. If the access is a read, capture it into the `rdata` register. Go to RESP.
- **RESP**
  - Assert the winner's ready for one cycle. The other port's ready stays 0. Go to IDLE.
- **Write data return:** on writes, `rdata` is not updated, so it keeps the previous read value.
- **Read data outputs:** `c_rdata` and `d_rdata` are both driven from the shared `rdata` register. Each is meaningful only while its own ready is high.
- **Requester rule:** a requester holds `req`, `we`, `addr` and `wdata` stable until it sees its ready.
  - Request inputs are sampled only in IDLE.
  - `req` still high in the cycle after ready is taken as a new request.
- **Non-winning port:** a losing or late requester waits in IDLE until it is granted. No request is ever dropped unless `reset` is asserted.
- **Reset**, including mid-access:
  - State goes to IDLE and `last` = D.
  - `m_en`, `m_we`, `c_ready`, `d_ready` and `busy` = 0.
  - Latched `m_addr`, `m_wdata` and `rdata` = 0.
  - Any in-flight access is abandoned and no ready is produced for it.

## Timing
- Request sampled in IDLE at cycle T:
  - ISSUE (`m_en`) at T+1.
  - WAIT from T+2 to T+1+LAT; `m_rdata` is captured at the end of T+1+LAT.
  - Ready at T+2+LAT.
- Latency from request to ready is LAT+2 cycles for both reads and writes. With LAT=2 that is 4 cycles.
- Earliest next grant is at the IDLE cycle T+3+LAT. Throughput is one access per LAT+3 cycles.
- `m_en` is never high in two consecutive cycles.
- Ready never coincides with `m_en`.
- `c_ready` and `d_ready` are never high together.

## Test plan
- **Reset values:** assert `reset` for 2 cycles → all outputs 0 and `busy` = 0. Deassert `reset` with no requests → stays idle, `m_en` = 0 forever.
- **Core read (LAT=2):** memory word 0x40 = 0xDEADBEEF; `c_req`=1, `c_we`=0, `c_addr`=0x40 at cycle T.
  - `m_en`=1, `m_addr`=0x40 at T+1.
  - `c_ready`=1 and `c_rdata`=0xDEADBEEF at T+4; `d_ready`=0 throughout.
- **Port D write then core read:** `d_req` writes 0x12345678 to 0x80.
  - `m_en`=1, `m_we`=1, `m_wdata`=0x12345678 one cycle after the request.
  - `d_ready` 4 cycles after the request; `d_rdata` unchanged from the prior value.
  - A following core read of 0x80 returns 0x12345678.
- **Simultaneous requests, both held:**
  - Out of reset, C is served first and D second; grants then alternate C, D, C, D.
  - Ready pulses are 5 cycles apart and never overlap.
- **Reset mid-access:** assert `reset` during WAIT of a core read → next cycle idle, no `c_ready`. Re-issued request then completes with normal LAT+2 latency.
- **LAT=1 and LAT=4 builds:** read latency is 3 and 6 cycles respectively, and `m_en` is exactly one cycle per access.
